// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state encoding and counter-width helper for serial_subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/full_sub_cell.sv
// full_sub_cell: 1-bit full subtractor; a - b - bin -> d with borrow-out bout
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock
// clk/rst: clock, async active-high reset; start/a/b/bin: request and operands;
// busy: running; done: one-cycle result pulse; diff/bout/ovf: held result
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = clog2(WIDTH);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff, w_res;
    logic [WIDTH-2:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow, r_bout, r_ovf;
    logic             w_d, w_bout, w_last, w_accept;
    full_sub_cell u_cell (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .bin (r_borrow),
        .d   (w_d),
        .bout(w_bout)
    );
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = start & (r_state != RUN);
    assign w_res    = {w_d, r_res};
    always_comb w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    // On the last RUN edge r_a[0]/r_b[0] hold the operand MSBs and w_d is the result MSB
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res[WIDTH-1:1];
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_bout;
                r_ovf  <= (r_a[0] != r_b[0]) & (w_d != r_a[0]);
            end
        end
    assign busy = r_state == RUN;
    assign done = r_state == DONE;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
endmodule
